instr_control_sequencer: RTL

- Hardwired control unit that drives the DataPath control lines: fetch, decode, execute, writeback for 3-register ALU instructions.
- Replaces hand-sequenced T0–T5 stimulus. Sits beside DataPath and reads the IR contents.
- Issues the ALU start/finished handshake as initiator.
- Instruction fields: op=IR[31:27], Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15].

---
 rtl/instr_control_sequencer.sv | 292 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/instr_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : instr_control_sequencer
//  Description : Hardwired control unit for the DataPath. It sequences
//                fetch (T0-T2), decode (DEC), operand read (T3), ALU issue
//                (T4), ALU wait (WAIT) and writeback (T5) for 3-register
//                ALU instructions. It also acts as the initiator of the ALU
//                start/finished handshake.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Optional feature macro: MULDIV_HILO_EN
//    When this macro is defined, mul/div results are written to HI/LO through
//    the TLO/THI states, and the RZHIout/RHIin/RLOin outputs are present.
// ----------------------------------------------------------------------------
//  Ports
//    Clock     in   1   system clock, rising edge
//    clear     in   1   asynchronous active-high reset
//    run       in   1   1 = execute; 0 = stop at next instruction boundary
//    IR        in  32   instruction register (op=31:27 Ra=26:23 Rb=22:19
//                       Rc=18:15)
//    finished  in   1   ALU completion
//    PCout..RFin out 1  DataPath strobes
//    RFSelect  out  4   register-file index
//    opSelect  out  6   ALU operation {1'b0, op}
//    start     out  1   ALU start, single-cycle pulse
//    halted    out  1   high while in HALT
//    err       out  1   sticky ALU-timeout flag
//    RZHIout, RHIin, RLOin out 1  (MULDIV_HILO_EN only) HI/LO strobes
// ============================================================================
module instr_control_sequencer #(
   parameter int ALU_TIMEOUT = 64,
   parameter int TMR_W       = 7
) (
   input  logic        Clock,
   input  logic        clear,
   input  logic        run,
   input  logic [31:0] IR,
   input  logic        finished,
   output logic        PCout,
   output logic        IncPC,
   output logic        MARin,
   output logic        RZin,
   output logic        RZLOout,
   output logic        PCin,
   output logic        Read,
   output logic        MDRin,
   output logic        MDRout,
   output logic        IRin,
   output logic        RFout,
   output logic        RYin,
   output logic        RFin,
   output logic [3:0]  RFSelect,
   output logic [5:0]  opSelect,
   output logic        start,
   output logic        halted,
   output logic        err
`ifdef MULDIV_HILO_EN
   ,
   output logic        RZHIout,
   output logic        RHIin,
   output logic        RLOin
`endif
);

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_T0   = 4'd1,
      S_T1   = 4'd2,
      S_T2   = 4'd3,
      S_DEC  = 4'd4,
      S_T3   = 4'd5,
      S_T4   = 4'd6,
      S_WAIT = 4'd7,
      S_T5   = 4'd8,
      S_HALT = 4'd9,
      S_TLO  = 4'd10,
      S_THI  = 4'd11
   } state_t;

   // Bit positions inside the strobe bundle.
   localparam int c_PCOUT  = 12;
   localparam int c_INCPC  = 11;
   localparam int c_MARIN  = 10;
   localparam int c_RZIN   = 9;
   localparam int c_RZLO   = 8;
   localparam int c_PCIN   = 7;
   localparam int c_READ   = 6;
   localparam int c_MDRIN  = 5;
   localparam int c_MDROUT = 4;
   localparam int c_IRIN   = 3;
   localparam int c_RFOUT  = 2;
   localparam int c_RYIN   = 1;
   localparam int c_RFIN   = 0;

   localparam logic [4:0]       c_OP_NOP  = 5'b00000;
   localparam logic [4:0]       c_OP_HALT = 5'b11111;
   localparam logic [TMR_W-1:0] c_TMO     = TMR_W'(ALU_TIMEOUT);

   state_t           r_state, w_next;
   logic [TMR_W-1:0] r_timer, w_timer;
   logic             r_err, w_err;

   logic [12:0]      r_strb, w_strb;
   logic [3:0]       r_sel, w_sel;
   logic [5:0]       r_op, w_op;
   logic             r_start, w_start;
   logic             r_halted, w_halted;

   logic [4:0]       w_opc;
   logic [3:0]       w_ra, w_rb, w_rc;
   logic             w_is_md;
   state_t           w_boundary;
   logic             w_unused_ir;

   assign w_opc       = IR[31:27];
   assign w_ra        = IR[26:23];
   assign w_rb        = IR[22:19];
   assign w_rc        = IR[18:15];
   assign w_unused_ir = ^IR[14:0];
   assign w_boundary  = run ? S_T0 : S_IDLE;

`ifdef MULDIV_HILO_EN
   logic r_rzhi, w_rzhi;
   logic r_rhi, w_rhi;
   logic r_rlo, w_rlo;
   assign w_is_md = (w_opc == 5'b01110) || (w_opc == 5'b01111);
`else
   assign w_is_md = 1'b0;
`endif

   // Next-state, timeout counter and sticky error.
   always_comb begin
      w_next  = r_state;
      w_timer = r_timer;
      w_err   = r_err;
      case (r_state)
         S_IDLE: if (run) w_next = S_T0;
         S_T0:   w_next = S_T1;
         S_T1:   w_next = S_T2;
         S_T2:   w_next = S_DEC;
         S_DEC: begin
            if (w_opc == c_OP_HALT)     w_next = S_HALT;
            else if (w_opc == c_OP_NOP) w_next = w_boundary;
            else                        w_next = S_T3;
         end
         S_T3: w_next = S_T4;
         S_T4: begin
            w_timer = '0;
            w_next  = S_WAIT;
         end
         S_WAIT: begin
            if (finished) begin
               w_next = w_is_md ? S_TLO : S_T5;
            end else begin
               w_timer = r_timer + 1'b1;
               // The timer counts completed WAIT cycles without finished.
               if (w_timer == c_TMO) begin
                  w_next = S_HALT;
                  w_err  = 1'b1;
               end
            end
         end
         S_T5:   w_next = w_boundary;
`ifdef MULDIV_HILO_EN
         S_TLO:  w_next = S_THI;
         S_THI:  w_next = w_boundary;
`endif
         S_HALT: w_next = S_HALT;
         default: w_next = S_IDLE;
      endcase
   end

   // The output decode runs on the upcoming state so that every output
   // is a flop whose value belongs to the state being entered.
   always_comb begin
      w_strb   = '0;
      w_sel    = '0;
      w_op     = '0;
      w_start  = 1'b0;
      w_halted = 1'b0;
`ifdef MULDIV_HILO_EN
      w_rzhi   = 1'b0;
      w_rhi    = 1'b0;
      w_rlo    = 1'b0;
`endif
      case (w_next)
         S_T0: begin
            w_strb[c_PCOUT] = 1'b1;
            w_strb[c_MARIN] = 1'b1;
            w_strb[c_INCPC] = 1'b1;
            w_strb[c_RZIN]  = 1'b1;
         end
         S_T1: begin
            w_strb[c_RZLO]  = 1'b1;
            w_strb[c_PCIN]  = 1'b1;
            w_strb[c_READ]  = 1'b1;
            w_strb[c_MDRIN] = 1'b1;
         end
         S_T2: begin
            w_strb[c_MDROUT] = 1'b1;
            w_strb[c_IRIN]   = 1'b1;
         end
         S_T3: begin
            w_sel           = w_rb;
            w_strb[c_RFOUT] = 1'b1;
            w_strb[c_RYIN]  = 1'b1;
         end
         S_T4, S_WAIT: begin
            w_sel           = w_rc;
            w_strb[c_RFOUT] = 1'b1;
            w_strb[c_RZIN]  = 1'b1;
            w_op            = {1'b0, w_opc};
            w_start         = (w_next == S_T4);
         end
         S_T5: begin
            w_sel          = w_ra;
            w_strb[c_RZLO] = 1'b1;
            w_strb[c_RFIN] = 1'b1;
         end
`ifdef MULDIV_HILO_EN
         S_TLO: begin
            w_strb[c_RZLO] = 1'b1;
            w_rlo          = 1'b1;
         end
         S_THI: begin
            w_rzhi = 1'b1;
            w_rhi  = 1'b1;
         end
`endif
         S_HALT: w_halted = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge Clock or posedge clear) begin
      if (clear) begin
         r_state  <= S_IDLE;
         r_timer  <= '0;
         r_err    <= 1'b0;
         r_strb   <= '0;
         r_sel    <= '0;
         r_op     <= '0;
         r_start  <= 1'b0;
         r_halted <= 1'b0;
`ifdef MULDIV_HILO_EN
         r_rzhi   <= 1'b0;
         r_rhi    <= 1'b0;
         r_rlo    <= 1'b0;
`endif
      end else begin
         r_state  <= w_next;
         r_timer  <= w_timer;
         r_err    <= w_err;
         r_strb   <= w_strb;
         r_sel    <= w_sel;
         r_op     <= w_op;
         r_start  <= w_start;
         r_halted <= w_halted;
`ifdef MULDIV_HILO_EN
         r_rzhi   <= w_rzhi;
         r_rhi    <= w_rhi;
         r_rlo    <= w_rlo;
`endif
      end
   end

   assign PCout    = r_strb[c_PCOUT];
   assign IncPC    = r_strb[c_INCPC];
   assign MARin    = r_strb[c_MARIN];
   assign RZin     = r_strb[c_RZIN];
   assign RZLOout  = r_strb[c_RZLO];
   assign PCin     = r_strb[c_PCIN];
   assign Read     = r_strb[c_READ];
   assign MDRin    = r_strb[c_MDRIN];
   assign MDRout   = r_strb[c_MDROUT];
   assign IRin     = r_strb[c_IRIN];
   assign RFout    = r_strb[c_RFOUT];
   assign RYin     = r_strb[c_RYIN];
   assign RFin     = r_strb[c_RFIN];
   assign RFSelect = r_sel;
   assign opSelect = r_op;
   assign start    = r_start;
   assign halted   = r_halted;
   assign err      = r_err;
`ifdef MULDIV_HILO_EN
   assign RZHIout  = r_rzhi;
   assign RHIin    = r_rhi;
   assign RLOin    = r_rlo;
`endif

endmodule
`default_nettype wire
